// File: rtl/aes_encrypt_round_pkg.sv
// Shared AES definitions: round counts, FSM encodings, byte/block types and GF(2^8) helpers.
package aes_encrypt_round_pkg;

  localparam logic [3:0] NR128 = 4'd10;
  localparam logic [3:0] NR192 = 4'd12;
  localparam logic [3:0] NR256 = 4'd14;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_LAST = 2'd2
  } aes_state_e;

  // Element 0 is the most significant byte, matching the [0:127] bus ordering.
  typedef logic [7:0]       byte_t;
  typedef logic [0:15][7:0] block_t;

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t mul2(input byte_t b);
    return xtime(b);
  endfunction

  function automatic byte_t mul3(input byte_t b);
    return xtime(b) ^ b;
  endfunction

  function automatic byte_t blk_byte(input block_t b, input int unsigned row, input int unsigned col);
    return b[4*col + row];
  endfunction

endpackage

// File: rtl/aes_encrypt_round_if.sv
// Handshake and data bus between the round controller, its requester and the round-key store.
interface aes_encrypt_round_if;
  logic [0:127] plaintext;
  logic         keylength128;
  logic         keylength192;
  logic         keylength256;
  logic         start;
  logic         busy_exp;
  logic [0:127] roundkey;
  logic [3:0]   round_count;
  logic [0:127] ciphertext;
  logic         done;
  logic         busy;

  modport slave (
    input  plaintext, keylength128, keylength192, keylength256, start, busy_exp, roundkey,
    output round_count, ciphertext, done, busy
  );

  modport master (
    output plaintext, keylength128, keylength192, keylength256, start, busy_exp, roundkey,
    input  round_count, ciphertext, done, busy
  );
endinterface

// File: rtl/aes_encrypt_round_sbox.sv
// Combinational AES forward S-box for one byte.
module aes_encrypt_round_sbox (
  input  logic [7:0] i_in,
  output logic [7:0] o_out
);

  localparam logic [0:2047] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign o_out = SBOX_TBL[{i_in, 3'b000} +: 8];

endmodule

// File: rtl/aes_encrypt_round.sv
// Iterative AES-128/192/256 encryption, one round per clock, driving the round-key store index.
// Optional build macro AES_ENC_ZEROIZE_EN clears the round state when the ciphertext is captured.
module aes_encrypt_round
  import aes_encrypt_round_pkg::*;
(
  input  logic               mclk,
  input  logic               arst_n,
  aes_encrypt_round_if.slave bus
);

  aes_state_e r_fsm, w_fsm_nxt;
  logic [3:0] r_rnd, w_rnd_nxt;
  logic [3:0] r_nr, w_nr_nxt;
  block_t     r_state, w_state_nxt;
  block_t     r_ct, w_ct_nxt;
  logic       r_done, w_done_nxt;
  logic       r_busy, w_busy_nxt;

  block_t     w_sub, w_sr, w_round, w_final;
  logic       w_accept;
  logic [3:0] w_nr_sel;

  function automatic block_t shift_rows(input block_t s);
    block_t o;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        o[4*c + r] = blk_byte(s, r, (c + r) % 4);
      end
    end
    return o;
  endfunction

  function automatic block_t mix_columns(input block_t s);
    block_t o;
    byte_t  a0, a1, a2, a3;
    for (int c = 0; c < 4; c++) begin
      a0 = s[4*c];
      a1 = s[4*c + 1];
      a2 = s[4*c + 2];
      a3 = s[4*c + 3];
      o[4*c]     = mul2(a0) ^ mul3(a1) ^ a2 ^ a3;
      o[4*c + 1] = a0 ^ mul2(a1) ^ mul3(a2) ^ a3;
      o[4*c + 2] = a0 ^ a1 ^ mul2(a2) ^ mul3(a3);
      o[4*c + 3] = mul3(a0) ^ a1 ^ a2 ^ mul2(a3);
    end
    return o;
  endfunction

  for (genvar g = 0; g < 16; g++) begin : g_sbox
    aes_encrypt_round_sbox u_sbox (.i_in(r_state[g]), .o_out(w_sub[g]));
  end

  assign w_sr     = shift_rows(w_sub);
  assign w_round  = mix_columns(w_sr) ^ bus.roundkey;
  assign w_final  = w_sr ^ bus.roundkey;
  assign w_accept = bus.start && !bus.busy_exp &&
                    (bus.keylength128 || bus.keylength192 || bus.keylength256);
  assign w_nr_sel = bus.keylength128 ? NR128 : (bus.keylength192 ? NR192 : NR256);

  // r_rnd doubles as the key-store index: 0 in IDLE, the round in RUN, Nr in LAST.
  assign bus.round_count = r_rnd;
  assign bus.ciphertext  = r_ct;
  assign bus.done        = r_done;
  assign bus.busy        = r_busy;

  // Next-state and datapath update for the round controller.
  always_comb begin
    w_fsm_nxt   = r_fsm;
    w_rnd_nxt   = r_rnd;
    w_nr_nxt    = r_nr;
    w_state_nxt = r_state;
    w_ct_nxt    = r_ct;
    w_done_nxt  = 1'b0;
    w_busy_nxt  = r_busy;
    case (r_fsm)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_nxt = bus.plaintext ^ bus.roundkey;
          w_nr_nxt    = w_nr_sel;
          w_rnd_nxt   = 4'd1;
          w_busy_nxt  = 1'b1;
          w_fsm_nxt   = ST_RUN;
        end else begin
          w_rnd_nxt   = 4'd0;
          w_busy_nxt  = 1'b0;
        end
      end
      ST_RUN: begin
        w_state_nxt = w_round;
        w_rnd_nxt   = r_rnd + 4'd1;
        if (r_rnd == (r_nr - 4'd1)) begin
          w_fsm_nxt = ST_LAST;
        end else begin
          w_fsm_nxt = ST_RUN;
        end
      end
      ST_LAST: begin
        w_ct_nxt    = w_final;
        w_done_nxt  = 1'b1;
        w_busy_nxt  = 1'b0;
        w_rnd_nxt   = 4'd0;
        w_fsm_nxt   = ST_IDLE;
`ifdef AES_ENC_ZEROIZE_EN
        w_state_nxt = '0;
`else
        w_state_nxt = r_state;
`endif
      end
      default: begin
        w_fsm_nxt  = ST_IDLE;
        w_rnd_nxt  = 4'd0;
        w_busy_nxt = 1'b0;
      end
    endcase
  end

  // State registers; reset discards any in-flight block without a done pulse.
  always_ff @(posedge mclk or negedge arst_n) begin
    if (!arst_n) begin
      r_fsm   <= ST_IDLE;
      r_rnd   <= 4'd0;
      r_nr    <= 4'd0;
      r_state <= '0;
      r_ct    <= '0;
      r_done  <= 1'b0;
      r_busy  <= 1'b0;
    end else begin
      r_fsm   <= w_fsm_nxt;
      r_rnd   <= w_rnd_nxt;
      r_nr    <= w_nr_nxt;
      r_state <= w_state_nxt;
      r_ct    <= w_ct_nxt;
      r_done  <= w_done_nxt;
      r_busy  <= w_busy_nxt;
    end
  end

endmodule
